// File: rtl/mcd_snd_pkg.sv
// mcd_snd_pkg
//   Shared types and constants for the Mega-CD audio summing stage.
//   sample_t  : signed 16-bit audio sample
//   gain_t    : unsigned 9-bit gain, 128 = unity, 256 = maximum
//   state_t   : mixer sequencer states
package mcd_snd_pkg;

  localparam int DATA_W     = 16;
  localparam int COEF_W     = 9;
  localparam int GAIN_UNITY = 128;
  localparam int GAIN_MAX   = 256;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic [COEF_W-1:0]        gain_t;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    SAT,
    OUT
  } state_t;

endpackage

// File: rtl/mcd_gain_ramp.sv
// mcd_gain_ramp
//   Per-source gain holder. The host writes a target gain at any time; the
//   active gain walks toward it by one step each time 'step' fires (once per
//   output sample), so gain changes never produce a click.
// Ports
//   clk_asic  in   system clock
//   rst       in   synchronous active-high reset (target = active = unity)
//   we        in   load a new target from din
//   din       in   requested gain, anything above GAIN_MAX is clamped
//   mute      in   treat the target as 0 while set
//   step      in   advance active gain one step toward the effective target
//   active    out  gain currently applied by the mixer
module mcd_gain_ramp
  import mcd_snd_pkg::*;
#(
  parameter int GAIN_W = COEF_W
) (
  input  logic              clk_asic,
  input  logic              rst,
  input  logic              we,
  input  logic [GAIN_W-1:0] din,
  input  logic              mute,
  input  logic              step,
  output logic [GAIN_W-1:0] active
);

  logic [GAIN_W-1:0] target;
  logic [GAIN_W-1:0] din_clamped;
  logic [GAIN_W-1:0] eff_target;

  always_comb begin
    din_clamped = (din > GAIN_W'(GAIN_MAX)) ? GAIN_W'(GAIN_MAX) : din;
    eff_target  = mute ? '0 : target;
  end

  // The ramp reads the registered target, so a write landing on the same
  // edge as 'step' only influences the following sample.
  always_ff @(posedge clk_asic) begin
    if (rst) begin
      target <= GAIN_W'(GAIN_UNITY);
      active <= GAIN_W'(GAIN_UNITY);
    end else begin
      if (we) begin
        target <= din_clamped;
      end
      if (step) begin
        if (active < eff_target) begin
          active <= active + 1'b1;
        end else if (active > eff_target) begin
          active <= active - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mcd_snd_mixer.sv
// mcd_snd_mixer
//   Final Mega-CD audio summing stage. Mixes faded CDDA, RF5C164 PCM and
//   MD FM/PSG into one saturated 16-bit stereo pair for the DAC serializer.
//   One multiplier is time-shared over six MAC steps per output sample.
//   Sequence: IDLE (accept) -> MAC x6 -> SAT -> OUT; mix_valid is high in
//   the 8th cycle after the cycle in which next_sample was accepted.
// Ports
//   clk_asic            in   system clock
//   rst                 in   synchronous active-high reset
//   next_sample         in   one-cycle strobe requesting a new output sample
//   cdda_l/r            in   signed CDDA samples from the fader
//   pcm_l/r             in   signed RF5C164 samples
//   fm_l/r              in   signed MD audio samples
//   gain_we             in   gain target write strobe
//   gain_sel            in   source index (0 CDDA, 1 PCM, 2 FM); others ignored
//   gain_din            in   requested gain, clamped to 256
//   mute_all            in   ramp every source toward zero while set
//   clip_clr            in   clear clip_l/r and overrun
//   mix_l/r             out  signed mixed output, held between updates
//   mix_valid           out  one-cycle strobe when mix_l/r update
//   clip_l/r            out  sticky saturation flags
//   overrun             out  sticky: next_sample arrived while busy
module mcd_snd_mixer
  import mcd_snd_pkg::*;
#(
  parameter int NSRC       = 3,
  parameter int GAIN_W     = COEF_W,
  parameter int GAIN_SHIFT = 7
) (
  input  logic              clk_asic,
  input  logic              rst,
  input  logic              next_sample,
  input  logic [15:0]       cdda_l,
  input  logic [15:0]       cdda_r,
  input  logic [15:0]       pcm_l,
  input  logic [15:0]       pcm_r,
  input  logic [15:0]       fm_l,
  input  logic [15:0]       fm_r,
  input  logic              gain_we,
  input  logic [1:0]        gain_sel,
  input  logic [GAIN_W-1:0] gain_din,
  input  logic              mute_all,
  input  logic              clip_clr,
  output logic [15:0]       mix_l,
  output logic [15:0]       mix_r,
  output logic              mix_valid,
  output logic              clip_l,
  output logic              clip_r,
  output logic              overrun
);

  localparam int NSTEP  = 2 * NSRC;
  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam int ACC_W  = PROD_W + 2;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  // Arithmetic shift (floor) by unity, then clamp to 16 bits.
  // Returns {clipped, value}.
  function automatic logic [DATA_W:0] sat_shift(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] s;
    s = acc >>> GAIN_SHIFT;
    if (s > SAT_MAX) begin
      return {1'b1, SAT_MAX[DATA_W-1:0]};
    end else if (s < SAT_MIN) begin
      return {1'b1, SAT_MIN[DATA_W-1:0]};
    end else begin
      return {1'b0, s[DATA_W-1:0]};
    end
  endfunction

  state_t state_q, state_d;
  logic [2:0] step_q;
  logic       accept;

  logic [GAIN_W-1:0] act [NSRC];

  sample_t snap_p0 [NSTEP];
  logic signed [ACC_W-1:0] acc_l_p1, acc_r_p1;

  sample_t                  mac_sample;
  logic [GAIN_W-1:0]        mac_gain;
  logic signed [PROD_W-1:0] mac_prod;
  logic [DATA_W:0]          sat_l, sat_r;

  assign accept = (state_q == IDLE) && next_sample;

  for (genvar i = 0; i < NSRC; i++) begin : g_ramp
    mcd_gain_ramp #(
      .GAIN_W(GAIN_W)
    ) u_ramp (
      .clk_asic(clk_asic),
      .rst     (rst),
      .we      (gain_we && (gain_sel == 2'(i))),
      .din     (gain_din),
      .mute    (mute_all),
      .step    (accept),
      .active  (act[i])
    );
  end

  always_ff @(posedge clk_asic) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        step_q <= '0;
      end else if (state_q == MAC) begin
        step_q <= step_q + 3'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (next_sample) state_d = MAC;
      MAC:     if (step_q == 3'(NSTEP - 1)) state_d = SAT;
      SAT:     state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: input snapshot taken on the accepting edge.
  always_ff @(posedge clk_asic) begin
    if (accept) begin
      snap_p0[0] <= cdda_l;
      snap_p0[1] <= cdda_r;
      snap_p0[2] <= pcm_l;
      snap_p0[3] <= pcm_r;
      snap_p0[4] <= fm_l;
      snap_p0[5] <= fm_r;
    end
  end

  // Shared multiplier: step k uses sample k and the gain of source k/2.
  // The gain is zero-extended so a value of 256 stays positive.
  always_comb begin
    mac_sample = snap_p0[step_q];
    mac_gain   = act[step_q[2:1]];
    mac_prod   = PROD_W'(mac_sample) * PROD_W'($signed({1'b0, mac_gain}));
    sat_l      = sat_shift(acc_l_p1);
    sat_r      = sat_shift(acc_r_p1);
  end

  // Stage p1: accumulation; output stage: saturate, publish and flag.
  // The flag sets sit after the clears so a coincident set wins.
  always_ff @(posedge clk_asic) begin
    if (rst) begin
      acc_l_p1  <= '0;
      acc_r_p1  <= '0;
      mix_l     <= '0;
      mix_r     <= '0;
      mix_valid <= 1'b0;
      clip_l    <= 1'b0;
      clip_r    <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      if (clip_clr) begin
        clip_l  <= 1'b0;
        clip_r  <= 1'b0;
        overrun <= 1'b0;
      end
      if (next_sample && (state_q != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (next_sample) begin
            acc_l_p1 <= '0;
            acc_r_p1 <= '0;
          end
        end
        MAC: begin
          if (step_q[0]) begin
            acc_r_p1 <= acc_r_p1 + ACC_W'(mac_prod);
          end else begin
            acc_l_p1 <= acc_l_p1 + ACC_W'(mac_prod);
          end
        end
        SAT: begin
          mix_l     <= sat_l[DATA_W-1:0];
          mix_r     <= sat_r[DATA_W-1:0];
          mix_valid <= 1'b1;
          if (sat_l[DATA_W]) clip_l <= 1'b1;
          if (sat_r[DATA_W]) clip_r <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcd_snd_mixer.sv
// tb_mcd_snd_mixer
//   Self-checking bench for mcd_snd_mixer: table-driven unity-gain vectors,
//   a gain/ramp reference model feeding a scoreboard queue, and hand-written
//   sequences for clip/clear races, overrun and mid-sequence reset.
module tb_mcd_snd_mixer;

  logic              clk_asic = 1'b0;
  logic              rst;
  logic              next_sample;
  logic signed [15:0] cdda_l, cdda_r, pcm_l, pcm_r, fm_l, fm_r;
  logic              gain_we;
  logic [1:0]        gain_sel;
  logic [8:0]        gain_din;
  logic              mute_all;
  logic              clip_clr;
  logic signed [15:0] mix_l, mix_r;
  logic              mix_valid, clip_l, clip_r, overrun;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int cl; int cr; int pl; int pr; int fl; int fr;
    int el; int er; int ecl; int ecr;
  } vec_t;

  typedef struct {
    int l;
    int r;
  } exp_t;

  vec_t vecs [4];
  exp_t sb [$];
  int   m_tgt [3];
  int   m_act [3];
  int   last_l, last_r;

  always #5 clk_asic = ~clk_asic;

  mcd_snd_mixer dut (
    .clk_asic   (clk_asic),
    .rst        (rst),
    .next_sample(next_sample),
    .cdda_l     (cdda_l),
    .cdda_r     (cdda_r),
    .pcm_l      (pcm_l),
    .pcm_r      (pcm_r),
    .fm_l       (fm_l),
    .fm_r       (fm_r),
    .gain_we    (gain_we),
    .gain_sel   (gain_sel),
    .gain_din   (gain_din),
    .mute_all   (mute_all),
    .clip_clr   (clip_clr),
    .mix_l      (mix_l),
    .mix_r      (mix_r),
    .mix_valid  (mix_valid),
    .clip_l     (clip_l),
    .clip_r     (clip_r),
    .overrun    (overrun)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_asic);
    #1;
  endtask

  function automatic int sat16(input int v);
    int s;
    s = v >>> 7;
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_tgt[i] = 128;
      m_act[i] = 128;
    end
  endtask

  task automatic model_step();
    int eff;
    for (int i = 0; i < 3; i++) begin
      eff = mute_all ? 0 : m_tgt[i];
      if (m_act[i] < eff) m_act[i]++;
      else if (m_act[i] > eff) m_act[i]--;
    end
  endtask

  function automatic exp_t model_value();
    exp_t e;
    e.l = sat16(int'(cdda_l) * m_act[0] + int'(pcm_l) * m_act[1] + int'(fm_l) * m_act[2]);
    e.r = sat16(int'(cdda_r) * m_act[0] + int'(pcm_r) * m_act[1] + int'(fm_r) * m_act[2]);
    return e;
  endfunction

  task automatic set_in(input int cl, input int cr, input int pl, input int pr,
                        input int fl, input int fr);
    cdda_l = 16'(cl); cdda_r = 16'(cr);
    pcm_l  = 16'(pl); pcm_r  = 16'(pr);
    fm_l   = 16'(fl); fm_r   = 16'(fr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_sample = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    sb.delete();
  endtask

  task automatic write_gain(input int sel, input int din);
    gain_sel = 2'(sel);
    gain_din = 9'(din);
    gain_we  = 1'b1;
    tick();
    gain_we  = 1'b0;
    if (sel < 3) m_tgt[sel] = (din > 256) ? 256 : din;
  endtask

  task automatic pulse_clr();
    clip_clr = 1'b1;
    tick();
    clip_clr = 1'b0;
  endtask

  // Called just after a rising edge with the mixer idle. Expected result is
  // either a table value or the reference model; ov_at / clr_at pulse
  // next_sample / clip_clr in that cycle of the sequence.
  task automatic run_sample(input string name, input bit use_tbl, input int el,
                            input int er, input int ov_at, input int clr_at);
    exp_t e;
    int   got;
    got = 0;
    model_step();
    if (use_tbl) begin
      e.l = el;
      e.r = er;
    end else begin
      e = model_value();
    end
    sb.push_back(e);
    next_sample = 1'b1;
    tick();
    next_sample = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk_asic);
      if (mix_valid) begin
        got = c;
        break;
      end
      next_sample = (c == ov_at);
      clip_clr    = (c == clr_at);
      if (c == ov_at) cdda_l = cdda_l + 16'sd1234;
    end
    next_sample = 1'b0;
    clip_clr    = 1'b0;
    chk({name, " latency"}, got, 8);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({name, " mix_l"}, int'(mix_l), e.l);
      chk({name, " mix_r"}, int'(mix_r), e.r);
    end
    last_l = int'(mix_l);
    last_r = int'(mix_r);
    @(posedge clk_asic);
    #1;
    chk({name, " valid pulse width"}, int'(mix_valid), 0);
  endtask

  task automatic expect_quiet(input string name, input int n);
    int cnt;
    cnt = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk_asic);
      if (mix_valid) cnt++;
    end
    chk(name, cnt, 0);
    @(posedge clk_asic);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; next_sample = 1'b0; gain_we = 1'b0; gain_sel = '0;
    gain_din = '0; mute_all = 1'b0; clip_clr = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    last_l = 0; last_r = 0;
    repeat (3) tick();
    rst = 1'b0;
    model_reset();

    chk("reset mix_l", int'(mix_l), 0);
    chk("reset mix_r", int'(mix_r), 0);
    chk("reset mix_valid", int'(mix_valid), 0);
    chk("reset clip_l", int'(clip_l), 0);
    chk("reset clip_r", int'(clip_r), 0);
    chk("reset overrun", int'(overrun), 0);

    vecs[0] = '{1000, 0, 2000, 0, -500, 0, 2500, 0, 0, 0};
    vecs[1] = '{100, -100, -300, 50, 7, 3, -193, -47, 0, 0};
    vecs[2] = '{32767, -32768, 32767, -32768, -32768, 32767, 32766, -32768, 0, 1};
    vecs[3] = '{30000, -30000, 30000, -30000, 30000, -30000, 32767, -32768, 1, 1};

    for (int i = 0; i < 4; i++) begin
      set_in(vecs[i].cl, vecs[i].cr, vecs[i].pl, vecs[i].pr, vecs[i].fl, vecs[i].fr);
      run_sample($sformatf("vec%0d", i), 1'b1, vecs[i].el, vecs[i].er, 0, 0);
      chk($sformatf("vec%0d clip_l", i), int'(clip_l), vecs[i].ecl);
      chk($sformatf("vec%0d clip_r", i), int'(clip_r), vecs[i].ecr);
    end

    pulse_clr();
    chk("clr clip_l", int'(clip_l), 0);
    chk("clr clip_r", int'(clip_r), 0);

    // clip_clr in the saturating cycle: the new clip must survive
    set_in(30000, 0, 30000, 0, 30000, 0);
    run_sample("clrset", 1'b1, 32767, 0, 0, 7);
    chk("clrset clip_l", int'(clip_l), 1);
    chk("clrset clip_r", int'(clip_r), 0);
    pulse_clr();

    // overrun: second strobe mid-sequence, inputs change, result unchanged
    set_in(1000, 0, 0, 0, 0, 0);
    run_sample("ovr", 1'b1, 1000, 0, 3, 0);
    chk("ovr flag", int'(overrun), 1);
    expect_quiet("ovr extra valid", 12);
    pulse_clr();
    chk("ovr cleared", int'(overrun), 0);

    // ramp down to gain 0
    write_gain(0, 0);
    set_in(12800, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 129; i++) begin
      run_sample($sformatf("rampdn%0d", i), 1'b0, 0, 0, 0, 0);
      if (i == 1)   chk("rampdn first", last_l, 12700);
      if (i == 64)  chk("rampdn mid", last_l, 6400);
      if (i == 128) chk("rampdn end", last_l, 0);
      if (i == 129) chk("rampdn hold", last_l, 0);
    end

    // floor behaviour of the arithmetic shift on a negative sum
    do_reset();
    write_gain(0, 127);
    set_in(-1, 0, 0, 0, 0, 0);
    run_sample("floor", 1'b1, -1, 0, 0, 0);

    // clamp of an oversize gain request
    do_reset();
    write_gain(0, 300);
    set_in(100, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 129; i++) begin
      run_sample($sformatf("rampup%0d", i), 1'b0, 0, 0, 0, 0);
    end
    chk("clamp mix_l", last_l, 200);
    write_gain(3, 0);
    run_sample("badsel", 1'b1, 200, 0, 0, 0);

    // mute ramps every source down one step per sample
    mute_all = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      run_sample($sformatf("mute%0d", i), 1'b0, 0, 0, 0, 0);
    end
    mute_all = 1'b0;
    chk("mute third", last_l, 197);

    // reset in the middle of a sequence
    set_in(1000, 0, 0, 0, 0, 0);
    next_sample = 1'b1;
    tick();
    next_sample = 1'b0;
    repeat (3) @(negedge clk_asic);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    sb.delete();
    chk("midrst mix_l", int'(mix_l), 0);
    chk("midrst mix_r", int'(mix_r), 0);
    expect_quiet("midrst no valid", 12);
    run_sample("postrst", 1'b1, 1000, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
